seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 4: divisor and remainder width; dividend and quotient are 2*WIDTH.
REQ-002 Parameter CONST_TIME, default 0: 1 disables every data-dependent early-out.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand request.
REQ-007 in_ready  out  1  high only in IDLE.
REQ-008 in_dividend  in  2*WIDTH  dividend, typically a MUL product.
REQ-009 in_divisor  in  WIDTH  divisor.
REQ-010 out_valid  out  1  result valid; high only in DONE.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_quotient  out  2*WIDTH  quotient.
REQ-013 out_remainder  out  WIDTH  remainder.
REQ-014 out_div_by_zero  out  1  result came from a zero divisor.

Function
REQ-015 FSM states: IDLE, CALC, DONE.
REQ-016 Accept: in_valid && in_ready at an edge latches the operands; inputs are ignored outside IDLE.
REQ-017 Accept transitions, CONST_TIME=0:
- IDLE->DONE if dividend==0 or divisor==0 (early-out).
- Otherwise IDLE->CALC.
REQ-018 Accept transitions, CONST_TIME=1: always IDLE->CALC.
REQ-019 CALC performs restoring division, one quotient bit per cycle, MSB first.
- Partial remainder held in WIDTH+1 bits.
- Iteration counter counts 2*WIDTH cycles, then CALC->DONE.
REQ-020 Latency, accept edge to out_valid rising:
- Normal: 2*WIDTH+1 cycles.
- Early-out: 1 cycle.
REQ-021 DONE holds out_valid and all result outputs stable until out_valid && out_ready, then DONE->IDLE.
REQ-022 No new operands are accepted in the cycle the result handshake completes; in_ready rises the next cycle.
REQ-023 Divisor zero, in either mode:
- out_quotient = all ones.
- out_remainder = dividend[WIDTH-1:0].
- out_div_by_zero = 1.
REQ-024 Dividend zero with nonzero divisor: quotient 0, remainder 0, out_div_by_zero 0.
REQ-025 Result invariants for a nonzero divisor:
- quotient*divisor + remainder == dividend.
- remainder < divisor.
REQ-026 Result outputs retain their last values in IDLE and CALC; they update only when entering DONE.

Reset
REQ-027 rst forces the following immediately, independent of clk: state IDLE, counter 0, out_valid 0, in_ready 1, out_quotient 0, out_remainder 0, out_div_by_zero 0.
REQ-028 rst asserted in CALC or DONE discards the operation; no out_valid follows.

Structure
REQ-029 Shared package div_pkg holds:
- WIDTH default.
- ITER = 2*WIDTH.
- FSM state enum.
- Divide-by-zero quotient constant.
REQ-030 One sub-module, div_step: a combinational single restoring iteration (partial remainder and next dividend bit in; new remainder and quotient bit out).
REQ-031 Top-level FSM, counter and output registers live in seq_divider; no other hierarchy.

Verification
REQ-032 100/7, CONST_TIME=0 -> quotient 14, remainder 2, div_by_zero 0; out_valid rises 9 cycles after accept.
REQ-033 0/5, CONST_TIME=0 -> quotient 0, remainder 0; out_valid 1 cycle after accept.
- Same stimulus with CONST_TIME=1 -> out_valid after 9 cycles.
REQ-034 37/0 -> quotient 0xFF, remainder 5, div_by_zero 1.
- Latency 1 cycle for CONST_TIME=0; 9 cycles for CONST_TIME=1.
REQ-035 225/15, out_ready held low 3 cycles in DONE -> out_valid and quotient 15, remainder 0 stable throughout; in_ready 0 until the cycle after the handshake.
REQ-036 rst pulsed 4 cycles after accepting 200/3 -> all outputs at reset values at once; no out_valid follows.
- Next request 200/3 -> quotient 66, remainder 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int ITER      = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Sliced down to 2*WIDTH by the user; all ones for any width.
  localparam logic [63:0] DBZ_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  localparam int RW = WIDTH + 1;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] dsr_x;

  assign trial   = {rem_in, bit_in};
  assign dsr_x   = {2'b00, divisor};
  assign q_bit   = (trial >= dsr_x);
  // Remainder stays below the divisor, so the top bit is always zero here.
  assign rem_out = RW'(q_bit ? (trial - dsr_x) : trial);
endmodule

// File: rtl/seq_divider.sv
// Sequential 2W/W restoring divider: one quotient bit per cycle, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0]   in_divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0]   out_remainder,
  output logic               out_div_by_zero
);
  localparam int CW = $clog2(2 * WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     rem;
  logic [2*WIDTH-1:0] dvd;
  logic [WIDTH-1:0]   dsr;
  logic [2*WIDTH-2:0] quot;

  logic [WIDTH:0]     step_rem;
  logic               step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[2*WIDTH-1]),
    .divisor (dsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      in_ready        <= 1'b1;
      out_valid       <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
      rem             <= '0;
      dvd             <= '0;
      dsr             <= '0;
      quot            <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          dvd      <= in_dividend;
          dsr      <= in_divisor;
          rem      <= '0;
          quot     <= '0;
          cnt      <= '0;
          in_ready <= 1'b0;
          if (!CONST_TIME && (in_dividend == '0 || in_divisor == '0)) begin
            state           <= DONE;
            out_valid       <= 1'b1;
            out_div_by_zero <= (in_divisor == '0);
            out_quotient    <= (in_divisor == '0) ? DBZ_QUOT[2*WIDTH-1:0] : '0;
            out_remainder   <= (in_divisor == '0) ? in_dividend[WIDTH-1:0] : '0;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          rem  <= step_rem;
          quot <= {quot[2*WIDTH-3:0], step_q};
          dvd  <= {dvd[2*WIDTH-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(2 * WIDTH - 1)) begin
            state           <= DONE;
            cnt             <= '0;
            out_valid       <= 1'b1;
            out_div_by_zero <= (dsr == '0);
            out_quotient    <= (dsr == '0) ? DBZ_QUOT[2*WIDTH-1:0] : {quot, step_q};
            // A zero divisor leaves the low dividend bits in the remainder naturally.
            out_remainder   <= step_rem[WIDTH-1:0];
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
